uart_word_tx: RTL and testbench

//  UART 8N1 serializer for one N_BITS data sample, feeding the Bluetooth module's RX pin.
//  - Sits directly downstream of the Bluetooth sample-streaming controller.
//  - Accepts a word on a start strobe and splits it into N_BITS/8 bytes, most significant byte first.
//  - Sends each byte as a start bit, 8 data bits (LSB first) and a stop bit.
//  - Pulses done when the whole word is on the line, so the controller can fetch the next sample.

---
 rtl/uart_word_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_word_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Serializes one N_BITS sample onto a UART 8N1 line, most significant byte
//   first, each byte framed as start(0), 8 data bits LSB-first, stop(1).
//   An optional idle-high gap separates the bytes of one word. The word
//   in flight is never disturbed by a new start request.
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   in_tx_start    request to send in_tx_data (taken only when idle)
//   in_tx_data     sample to send, captured in the accept cycle
//   out_tx_active  high while a word is on the line
//   out_tx_serial  UART line, idle high
//   out_tx_done    one-cycle pulse after the last stop bit of the word
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_BITS       = 32,
  parameter int GAP_CLKS     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_tx_start,
  input  logic [N_BITS-1:0] in_tx_data,
  output logic              out_tx_active,
  output logic              out_tx_serial,
  output logic              out_tx_done
);

  localparam int NB = N_BITS / 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NB) + 1;
  // The gap counter is separate from clk_cnt because GAP_CLKS may exceed a bit time.
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_clk_cnt;
  logic [GW-1:0]     r_gap_cnt;
  logic [2:0]        r_bit_idx;
  logic [BW-1:0]     r_byte_idx;
  logic [N_BITS-1:0] r_shift;
  logic              r_serial;
  logic              r_active;
  logic              r_done;

  // The byte being sent always sits in the top 8 bits of the shift register.
  logic [7:0] w_cur_byte;
  logic [2:0] w_bit_next;

  assign w_cur_byte = r_shift[N_BITS-1 -: 8];
  assign w_bit_next = r_bit_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serial  <= 1'b1;
          r_active  <= 1'b0;
          r_clk_cnt <= '0;
          r_gap_cnt <= '0;
          if (in_tx_start) begin
            r_shift    <= in_tx_data;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_state    <= S_START_BIT;
            r_serial   <= 1'b0;
            r_active   <= 1'b1;
          end
        end

        S_START_BIT: begin
          if (r_clk_cnt == CNT_LAST) begin
            // Output is registered, so the first data bit is loaded one
            // cycle before its bit period begins.
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA_BITS;
            r_serial  <= w_cur_byte[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DATA_BITS: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state  <= S_STOP_BIT;
              r_serial <= 1'b1;
            end else begin
              r_bit_idx <= w_bit_next;
              r_serial  <= w_cur_byte[w_bit_next];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_STOP_BIT: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            if (r_byte_idx < BYTE_LAST) begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_shift    <= r_shift << 8;
              if (GAP_CLKS > 0) begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
                r_serial  <= 1'b1;
              end else begin
                r_state  <= S_START_BIT;
                r_serial <= 1'b0;
              end
            end else begin
              r_state  <= S_IDLE;
              r_serial <= 1'b1;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= S_START_BIT;
            r_serial  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign out_tx_active = r_active;
  assign out_tx_serial = r_serial;
  assign out_tx_done   = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx
//   Directed bench for uart_word_tx using three instances:
//   dut0 CLKS_PER_BIT=4 N_BITS=32 GAP_CLKS=0, dut1 same with GAP_CLKS=3,
//   dut2 CLKS_PER_BIT=2 N_BITS=8. Line activity is captured cycle by cycle
//   relative to the accept cycle T and compared to expected frames.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic [7:0]  data2 = '0;
  logic        act0, ser0, done0;
  logic        act1, ser1, done1;
  logic        act2, ser2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_ser  [0:340];
  logic cap_act  [0:340];
  logic cap_done [0:340];

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(4), .N_BITS(32), .GAP_CLKS(0)) dut0 (
    .clk(clk), .rst(rst), .in_tx_start(start0), .in_tx_data(data0),
    .out_tx_active(act0), .out_tx_serial(ser0), .out_tx_done(done0));

  uart_word_tx #(.CLKS_PER_BIT(4), .N_BITS(32), .GAP_CLKS(3)) dut1 (
    .clk(clk), .rst(rst), .in_tx_start(start1), .in_tx_data(data1),
    .out_tx_active(act1), .out_tx_serial(ser1), .out_tx_done(done1));

  uart_word_tx #(.CLKS_PER_BIT(2), .N_BITS(8), .GAP_CLKS(0)) dut2 (
    .clk(clk), .rst(rst), .in_tx_start(start2), .in_tx_data(data2),
    .out_tx_active(act2), .out_tx_serial(ser2), .out_tx_done(done2));

  // Expected line level at cycle offset c (1-based) of a word accepted at T.
  function automatic logic exp_bit(input logic [31:0] d, input int nb, input int cpb,
                                   input int gap, input int c);
    int idx, per, b, r, p;
    logic [31:0] sh;
    idx = c - 1;
    per = 10 * cpb + gap;
    b   = idx / per;
    r   = idx % per;
    if (r >= 10 * cpb) return 1'b1;
    p = r / cpb;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    sh = d >> (8 * (nb - 1 - b));
    return sh[p-1];
  endfunction

  // Starts a word on instance k in the current cycle (T) and records outputs
  // for cycles T+1..T+n. Optional start pulses at inj_at/inj2_at carry inj_d,
  // and rst is raised during cycle rst_at. Offsets of 0 disable an action.
  task automatic capture(input int k, input int n, input logic [31:0] d0,
                         input int inj_at, input int inj2_at, input logic [31:0] inj_d,
                         input int rst_at);
    case (k)
      0: begin start0 = 1'b1; data0 = d0; end
      1: begin start1 = 1'b1; data1 = d0; end
      default: begin start2 = 1'b1; data2 = d0[7:0]; end
    endcase
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      rst = (c == rst_at);
      case (k)
        0: begin
          start0 = (c == inj_at) || (c == inj2_at);
          if (start0) data0 = inj_d;
          cap_ser[c] = ser0; cap_act[c] = act0; cap_done[c] = done0;
        end
        1: begin
          start1 = (c == inj_at) || (c == inj2_at);
          if (start1) data1 = inj_d;
          cap_ser[c] = ser1; cap_act[c] = act1; cap_done[c] = done1;
        end
        default: begin
          start2 = (c == inj_at) || (c == inj2_at);
          if (start2) data2 = inj_d[7:0];
          cap_ser[c] = ser2; cap_act[c] = act2; cap_done[c] = done2;
        end
      endcase
    end
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cycles(3);
    n_checks++; if (ser0 !== 1'b1) begin n_fail++; $display("FAIL reset_ser0 got %b want 1", ser0); end
    n_checks++; if (act0 !== 1'b0) begin n_fail++; $display("FAIL reset_act0 got %b want 0", act0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done0 got %b want 0", done0); end
    n_checks++; if (ser1 !== 1'b1 || act1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut1 got ser=%b act=%b done=%b want 1 0 0", ser1, act1, done1); end
    n_checks++; if (ser2 !== 1'b1 || act2 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut2 got ser=%b act=%b done=%b want 1 0 0", ser2, act2, done2); end
    rst = 1'b0;
    idle_cycles(2);
    $display("test_reset done");
  endtask

  task automatic test_word;
    int errs, first;
    capture(0, 170, 32'hA5C30F01, 0, 0, 32'h0, 0);
    errs = 0; first = -1;
    for (int c = 1; c <= 160; c++)
      if (cap_ser[c] !== exp_bit(32'hA5C30F01, 4, 4, 0, c)) begin errs++; if (first < 0) first = c; end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL word_serial got %0d bad cycles (first T+%0d) want 0", errs, first); end
    errs = 0;
    for (int c = 1; c <= 170; c++) if (cap_act[c] !== (c <= 160)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL word_active got %0d bad cycles want 0", errs); end
    errs = 0;
    for (int c = 1; c <= 170; c++) if (cap_done[c] !== (c == 161)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL word_done got %0d bad cycles want 0", errs); end
    n_checks++; if (cap_ser[5] !== 1'b1 || cap_ser[9] !== 1'b0 || cap_ser[40] !== 1'b1 || cap_ser[41] !== 1'b0) begin
      n_fail++; $display("FAIL word_spot got %b%b%b%b want 1010", cap_ser[5], cap_ser[9], cap_ser[40], cap_ser[41]); end
    n_checks++; if (cap_ser[161] !== 1'b1) begin n_fail++; $display("FAIL word_idle_after got %b want 1", cap_ser[161]); end
    idle_cycles(3);
    $display("test_word done");
  endtask

  task automatic test_ignore_start;
    int errs;
    capture(0, 170, 32'hA5C30F01, 50, 100, 32'h12345678, 0);
    errs = 0;
    for (int c = 1; c <= 160; c++) if (cap_ser[c] !== exp_bit(32'hA5C30F01, 4, 4, 0, c)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL ignore_serial got %0d bad cycles want 0", errs); end
    errs = 0;
    for (int c = 1; c <= 170; c++) if (cap_done[c] !== (c == 161) || cap_act[c] !== (c <= 160)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL ignore_done_active got %0d bad cycles want 0", errs); end
    idle_cycles(3);
    $display("test_ignore_start done");
  endtask

  task automatic test_back_to_back;
    int errs;
    capture(0, 330, 32'hA5C30F01, 161, 0, 32'h00000000, 0);
    errs = 0;
    for (int c = 1; c <= 160; c++) if (cap_ser[c] !== exp_bit(32'hA5C30F01, 4, 4, 0, c)) errs++;
    for (int c = 162; c <= 321; c++) if (cap_ser[c] !== exp_bit(32'h0, 4, 4, 0, c - 161)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_serial got %0d bad cycles want 0", errs); end
    n_checks++; if (cap_ser[162] !== 1'b0) begin n_fail++; $display("FAIL b2b_start_edge got %b want 0", cap_ser[162]); end
    errs = 0;
    for (int c = 1; c <= 330; c++) if (cap_done[c] !== (c == 161 || c == 322)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_done got %0d bad cycles want 0", errs); end
    errs = 0;
    for (int c = 1; c <= 330; c++) if (cap_act[c] !== ((c <= 160) || (c >= 162 && c <= 321))) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_active got %0d bad cycles want 0", errs); end
    idle_cycles(3);
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_word;
    int errs;
    capture(0, 180, 32'hA5C30F01, 0, 0, 32'h0, 70);
    errs = 0;
    for (int c = 1; c <= 69; c++) if (cap_ser[c] !== exp_bit(32'hA5C30F01, 4, 4, 0, c)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL abort_prefix got %0d bad cycles want 0", errs); end
    errs = 0;
    for (int c = 71; c <= 180; c++) if (cap_ser[c] !== 1'b1 || cap_act[c] !== 1'b0 || cap_done[c] !== 1'b0) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL abort_idle got %0d bad cycles want 0", errs); end
    idle_cycles(2);
    capture(0, 170, 32'h3C96E17B, 0, 0, 32'h0, 0);
    errs = 0;
    for (int c = 1; c <= 160; c++) if (cap_ser[c] !== exp_bit(32'h3C96E17B, 4, 4, 0, c)) errs++;
    for (int c = 1; c <= 170; c++) if (cap_done[c] !== (c == 161)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL after_reset_word got %0d bad cycles want 0", errs); end
    idle_cycles(3);
    $display("test_reset_mid_word done");
  endtask

  task automatic test_gap;
    int errs;
    capture(1, 175, 32'hFF00FF00, 0, 0, 32'h0, 0);
    errs = 0;
    for (int c = 1; c <= 169; c++) if (cap_ser[c] !== exp_bit(32'hFF00FF00, 4, 4, 3, c)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL gap_serial got %0d bad cycles want 0", errs); end
    n_checks++; if (cap_ser[41] !== 1'b1 || cap_ser[43] !== 1'b1 || cap_ser[44] !== 1'b0 || cap_act[42] !== 1'b1) begin
      n_fail++; $display("FAIL gap_spot got ser41=%b ser43=%b ser44=%b act42=%b want 1 1 0 1",
                         cap_ser[41], cap_ser[43], cap_ser[44], cap_act[42]); end
    errs = 0;
    for (int c = 1; c <= 175; c++) if (cap_done[c] !== (c == 170) || cap_act[c] !== (c <= 169)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL gap_done_active got %0d bad cycles want 0", errs); end
    idle_cycles(3);
    $display("test_gap done");
  endtask

  task automatic test_narrow;
    int errs;
    capture(2, 25, 32'h00000080, 0, 0, 32'h0, 0);
    errs = 0;
    for (int c = 1; c <= 20; c++) if (cap_ser[c] !== (c >= 17)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL narrow_serial got %0d bad cycles want 0", errs); end
    errs = 0;
    for (int c = 1; c <= 25; c++) if (cap_done[c] !== (c == 21) || cap_act[c] !== (c <= 20)) errs++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL narrow_done_active got %0d bad cycles want 0", errs); end
    idle_cycles(3);
    $display("test_narrow done");
  endtask

  initial begin
    #1;
    test_reset;
    test_word;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_word;
    test_gap;
    test_narrow;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
